// File: rtl/mem_resp.sv
// Multi-cycle data memory responder: load/store with byte lanes, sign extension,
// alignment errors and a fixed number of wait states per access.
module mem_resp #(
   parameter int WAIT       = 2,
   parameter int DEPTH_LOG2 = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req,
   input  logic        we,
   input  logic [1:0]  size,
   input  logic        sign_ext,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        ready,
   output logic        err,
   output logic        busy
);

   // state | meaning
   // IDLE  | waiting for req; request fields sampled here
   // BUSY  | counting wait states
   // DONE  | access completed this cycle, ready asserted
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   localparam int AW = DEPTH_LOG2 + 2;
   localparam logic [3:0] WAIT_LAST = 4'(WAIT - 1);

   state_t          state, state_nxt;
   logic [3:0]      cnt, cnt_nxt;
   logic [AW-1:0]   addr_q;
   logic            we_q, sext_q, err_q;
   logic [1:0]      size_q;
   logic [31:0]     wdata_q;
   logic [31:0]     mem [0:(1<<DEPTH_LOG2)-1];

   logic [AW-1:0]   cur_addr;
   logic            cur_we, cur_sext, bad, enter_done;
   logic [1:0]      cur_size;
   logic [31:0]     cur_wdata, rd_word, wr_word, ld_val;
   logic [7:0]      rd_byte;
   logic [15:0]     rd_half;
   logic            unused_addr;

   assign unused_addr = ^addr[31:AW];

   // With WAIT=0 the access completes on the sampling edge, so the live inputs are used.
   assign cur_addr  = (state == IDLE) ? addr[AW-1:0] : addr_q;
   assign cur_we    = (state == IDLE) ? we           : we_q;
   assign cur_size  = (state == IDLE) ? size         : size_q;
   assign cur_sext  = (state == IDLE) ? sign_ext     : sext_q;
   assign cur_wdata = (state == IDLE) ? wdata        : wdata_q;

   assign bad = (cur_size == 2'd3) ||
                ((cur_size == 2'd1) && cur_addr[0]) ||
                ((cur_size == 2'd2) && (cur_addr[1:0] != 2'd0));

   assign rd_word = mem[cur_addr[AW-1:2]];

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: if (req) begin
            cnt_nxt   = '0;
            state_nxt = (WAIT == 0) ? DONE : BUSY;
         end
         BUSY: begin
            cnt_nxt = cnt + 4'd1;
            if (cnt == WAIT_LAST) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign enter_done = (state_nxt == DONE);

   always_comb begin
      rd_byte = rd_word[7:0];
      case (cur_addr[1:0])
         2'd1:    rd_byte = rd_word[15:8];
         2'd2:    rd_byte = rd_word[23:16];
         2'd3:    rd_byte = rd_word[31:24];
         default: rd_byte = rd_word[7:0];
      endcase
      rd_half = cur_addr[1] ? rd_word[31:16] : rd_word[15:0];
      case (cur_size)
         2'd0:    ld_val = {{24{cur_sext & rd_byte[7]}}, rd_byte};
         2'd1:    ld_val = {{16{cur_sext & rd_half[15]}}, rd_half};
         default: ld_val = rd_word;
      endcase
   end

   always_comb begin
      wr_word = rd_word;
      case (cur_size)
         2'd0: wr_word[{cur_addr[1:0], 3'b000} +: 8] = cur_wdata[7:0];
         2'd1: begin
            if (cur_addr[1]) wr_word[31:16] = cur_wdata[15:0];
            else             wr_word[15:0]  = cur_wdata[15:0];
         end
         2'd2:    wr_word = cur_wdata;
         default: wr_word = rd_word;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         addr_q  <= '0;
         we_q    <= 1'b0;
         size_q  <= 2'd0;
         sext_q  <= 1'b0;
         wdata_q <= '0;
         err_q   <= 1'b0;
         rdata   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (state == IDLE && req) begin
            addr_q  <= addr[AW-1:0];
            we_q    <= we;
            size_q  <= size;
            sext_q  <= sign_ext;
            wdata_q <= wdata;
         end
         if (enter_done) begin
            err_q <= bad;
            if (bad)         rdata <= '0;
            else if (!cur_we) rdata <= ld_val;
         end
      end
   end

   // Array is deliberately not reset; a reset mid-access must still block the write.
   always_ff @(posedge clk) begin
      if (rst_n && enter_done && cur_we && !bad)
         mem[cur_addr[AW-1:2]] <= wr_word;
   end

   assign busy  = (state != IDLE);
   assign ready = (state == DONE);
   assign err   = ready & err_q;

endmodule

// File: tb/tb_mem_resp.sv
// Self-checking bench for mem_resp: byte-addressed timeline model checked every
// cycle, plus directed accesses with hand-computed results.
module tb_mem_resp;
   localparam int WAIT = 2;

   logic        clk = 1'b0;
   logic        rst_n, req, we, sign_ext;
   logic [1:0]  size;
   logic [31:0] addr, wdata, rdata;
   logic        ready, err, busy;

   int n_tests = 0;
   int n_fail  = 0;
   logic chk_en = 1'b0;

   always #5 clk = ~clk;

   mem_resp #(.WAIT(WAIT), .DEPTH_LOG2(8)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size),
      .sign_ext(sign_ext), .addr(addr), .wdata(wdata),
      .rdata(rdata), .ready(ready), .err(err), .busy(busy)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model: byte memory + completion timeline
   logic [7:0]  mem_b [1024];
   logic        m_ready, m_err;
   logic [31:0] m_rdata;
   int          m_remain;
   logic        l_we, l_sext;
   logic [1:0]  l_size;
   logic [31:0] l_addr, l_wdata;
   logic        m_busy;

   assign m_busy = m_ready || (m_remain > 0);

   function automatic logic model_bad(input logic [31:0] a, input logic [1:0] sz);
      if (sz == 2'd3) return 1'b1;
      return (a % (32'd1 << sz)) != 0;
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz,
                                              input logic sx);
      logic [31:0] v;
      int n;
      v = 0;
      n = 1 << sz;
      for (int i = 0; i < n; i++)
         v = v | (32'(mem_b[a[9:0] + 10'(i)]) << (8 * i));
      if (sx && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
      return v;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_ready  <= 1'b0;
         m_err    <= 1'b0;
         m_rdata  <= '0;
         m_remain <= -1;
      end else if (m_ready) begin
         m_ready <= 1'b0;
      end else if (m_remain > 0) begin
         if (m_remain == 1) begin
            m_ready <= 1'b1;
            m_err   <= model_bad(l_addr, l_size);
            if (model_bad(l_addr, l_size)) m_rdata <= '0;
            else if (!l_we) m_rdata <= model_load(l_addr, l_size, l_sext);
            else begin
               for (int i = 0; i < 4; i++)
                  if (i < (1 << l_size)) mem_b[l_addr[9:0] + 10'(i)] <= l_wdata[8*i +: 8];
            end
         end
         m_remain <= m_remain - 1;
      end else if (req) begin
         l_we     <= we;
         l_size   <= size;
         l_sext   <= sign_ext;
         l_addr   <= addr;
         l_wdata  <= wdata;
         m_remain <= WAIT;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("ready", {31'd0, ready}, {31'd0, m_ready});
         chk("busy",  {31'd0, busy},  {31'd0, m_busy});
         chk("rdata", rdata, m_rdata);
         if (m_ready) chk("err", {31'd0, err}, {31'd0, m_err});
      end
   end

   // ---------------- directed stimulus
   task automatic acc(input logic w, input logic [1:0] sz, input logic sx,
                      input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output logic e, output int lat, output int bcnt);
      logic found;
      found = 1'b0;
      rd = 'x; e = 1'bx; lat = -1; bcnt = 0;
      @(posedge clk); #2;
      req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = wd;
      @(posedge clk); #2;
      req = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (busy) bcnt++;
         if (ready) begin
            rd = rdata; e = err; lat = i; found = 1'b1;
         end
      end
      if (!found) begin
         n_tests++;
         n_fail++;
         $display("FAIL timeout: no ready for addr %h", a);
      end
   endtask

   task automatic load_chk(input string nm, input logic [1:0] sz, input logic sx,
                           input logic [31:0] a, input logic [31:0] exp_rd, input logic exp_err);
      logic [31:0] rd; logic e; int lat, bc;
      acc(1'b0, sz, sx, a, 32'h0, rd, e, lat, bc);
      chk({nm, "_rdata"}, rd, exp_rd);
      chk({nm, "_err"}, {31'd0, e}, {31'd0, exp_err});
   endtask

   task automatic store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                        input logic exp_err);
      logic [31:0] rd; logic e; int lat, bc;
      acc(1'b1, sz, 1'b0, a, wd, rd, e, lat, bc);
      chk("store_err", {31'd0, e}, {31'd0, exp_err});
   endtask

   initial begin
      logic [31:0] rd;
      logic e;
      int lat, bc, np, p0, p1;
      foreach (mem_b[i]) mem_b[i] = 8'h00;
      rst_n = 1'b0; req = 1'b0; we = 1'b0; size = 2'd0; sign_ext = 1'b0;
      addr = '0; wdata = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", {31'd0, ready}, 32'd0);
      chk("rst_busy",  {31'd0, busy},  32'd0);
      chk("rst_err",   {31'd0, err},   32'd0);
      chk("rst_rdata", rdata, 32'd0);
      @(posedge clk); #2;
      rst_n  = 1'b1;
      chk_en = 1'b1;

      // word store/load latency and busy length
      acc(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, rd, e, lat, bc);
      chk("sw_lat", 32'(lat), 32'd2);
      chk("sw_busy", 32'(bc), 32'd3);
      chk("sw_err", {31'd0, e}, 32'd0);
      acc(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, e, lat, bc);
      chk("lw_lat", 32'(lat), 32'd2);
      chk("lw_busy", 32'(bc), 32'd3);
      chk("lw_rdata", rd, 32'hDEADBEEF);
      chk("lw_err", {31'd0, e}, 32'd0);

      // byte lanes
      store(2'd2, 32'h20, 32'h11223344, 1'b0);
      store(2'd0, 32'h21, 32'h000000AA, 1'b0);
      load_chk("lbu21", 2'd0, 1'b0, 32'h21, 32'h000000AA, 1'b0);
      load_chk("lb21",  2'd0, 1'b1, 32'h21, 32'hFFFFFFAA, 1'b0);
      load_chk("lw20",  2'd2, 1'b0, 32'h20, 32'h1122AA44, 1'b0);
      load_chk("lb20",  2'd0, 1'b1, 32'h20, 32'h00000044, 1'b0);

      // halfwords
      store(2'd2, 32'h40, 32'h11228344, 1'b0);
      load_chk("lh42",  2'd1, 1'b1, 32'h42, 32'h00001122, 1'b0);
      load_chk("lhu42", 2'd1, 1'b0, 32'h42, 32'h00001122, 1'b0);
      load_chk("lh40",  2'd1, 1'b1, 32'h40, 32'hFFFF8344, 1'b0);
      load_chk("lhu40", 2'd1, 1'b0, 32'h40, 32'h00008344, 1'b0);

      // misaligned and reserved size
      load_chk("lw22", 2'd2, 1'b0, 32'h22, 32'h0, 1'b1);
      acc(1'b1, 2'd1, 1'b0, 32'h23, 32'h0000BEEF, rd, e, lat, bc);
      chk("sh23_err", {31'd0, e}, 32'd1);
      chk("sh23_rdata", rd, 32'h0);
      chk("sh23_lat", 32'(lat), 32'd2);
      load_chk("sz3", 2'd3, 1'b0, 32'h20, 32'h0, 1'b1);
      load_chk("lw20b", 2'd2, 1'b0, 32'h20, 32'h1122AA44, 1'b0);

      // req held high for 10 cycles
      @(posedge clk); #2;
      req = 1'b1; we = 1'b0; size = 2'd2; sign_ext = 1'b0; addr = 32'h20;
      np = 0; p0 = -1; p1 = -1;
      @(posedge clk);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (ready) begin
            if (np == 0) p0 = i; else p1 = i;
            np++;
         end
         if (i < 9) @(posedge clk);
      end
      @(posedge clk); #2;
      req = 1'b0;
      chk("held_count", 32'(np), 32'd2);
      chk("held_gap", 32'(p1 - p0), 32'd4);
      for (int i = 0; i < 20 && busy; i++) @(negedge clk);
      chk("held_drain", {31'd0, busy}, 32'd0);

      // reset abort in BUSY
      store(2'd2, 32'h30, 32'h55555555, 1'b0);
      @(posedge clk); #2;
      req = 1'b1; we = 1'b1; size = 2'd2; addr = 32'h30; wdata = 32'h12345678;
      @(posedge clk); #2;
      req = 1'b0;
      rst_n = 1'b0;
      @(posedge clk); #2;
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("abort_ready", {31'd0, ready}, 32'd0);
      end
      load_chk("lw30", 2'd2, 1'b0, 32'h30, 32'h55555555, 1'b0);

      // address wrap
      store(2'd2, 32'h400, 32'hCAFEF00D, 1'b0);
      load_chk("wrap", 2'd2, 1'b0, 32'h0, 32'hCAFEF00D, 1'b0);
      load_chk("lw10b", 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);

      @(posedge clk); @(negedge clk);
      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_resp.md
MEM_RESP -- requirements
Module: mem_resp

Interface
REQ-001 Parameter WAIT, default 2, meaning: added wait-state cycles per access, legal range 0..15.
REQ-002 Parameter DEPTH_LOG2, default 8, meaning: log2 of the internal word count (default 256 x 32-bit words).
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req  input  1  access request from the multi-cycle datapath, sampled only in IDLE.
REQ-006 we  input  1  1 = store, 0 = load.
REQ-007 size  input  2  0 = byte, 1 = halfword, 2 = word, 3 = reserved.
REQ-008 sign_ext  input  1  loads only: 1 = sign-extend (lb/lh), 0 = zero-extend (lbu/lhu).
REQ-009 addr  input  32  byte address.
REQ-010 wdata  input  32  store data, right-justified for byte/halfword.
REQ-011 rdata  output  32  load result, right-justified and extended.
REQ-012 ready  output  1  one-cycle completion strobe.
REQ-013 err  output  1  error flag, valid only while ready = 1.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 The FSM SHALL have the states IDLE, BUSY and DONE, encoded in a registered state variable.
REQ-016 IDLE with req=1 at edge E0 SHALL latch addr, we, size, sign_ext and wdata, clear the wait counter, and go to BUSY, or go directly to DONE when WAIT=0.
REQ-017 BUSY SHALL increment the counter each edge and go to DONE on the edge where the counter equals WAIT-1.
REQ-018 ready SHALL be 1 for exactly the one cycle following edge E0+WAIT, and 0 at all other times.
REQ-019 DONE SHALL return to IDLE unconditionally, so back-to-back throughput is one access per WAIT+2 cycles.
REQ-020 req SHALL be ignored in BUSY and DONE; a req held high through DONE SHALL be accepted as a new access on the first IDLE edge.
REQ-021 Word index SHALL be addr[DEPTH_LOG2+1:2]; upper address bits SHALL be ignored, so addresses wrap modulo the memory size.
REQ-022 Byte lanes SHALL be little-endian: lane k holds bits [8k+7:8k] and is selected by addr[1:0].
REQ-023 Loads: rdata SHALL be updated on the edge entering DONE and held until the next completion.
REQ-024 Byte loads SHALL return lane addr[1:0]; halfword loads SHALL return lanes addr[1]*2 and addr[1]*2+1.
REQ-025 Byte and halfword loads SHALL be extended to 32 bits per sign_ext; word loads SHALL return the full word.
REQ-026 Stores SHALL commit on the edge entering DONE and SHALL modify only the addressed lanes, taken from the low byte(s) of wdata.
REQ-027 Stores SHALL leave the other lanes unchanged (read-modify-write of the word).
REQ-028 Stores SHALL leave rdata unchanged.
REQ-029 A misaligned access (size=1 with addr[0]=1, size=2 with addr[1:0]!=0) or size=3 SHALL complete with normal ready timing and err=1.
REQ-030 An access with err=1 SHALL perform no write and SHALL set rdata to 0.
REQ-031 err SHALL be 0 for every legal access.
REQ-032 A store followed by a load of the same address SHALL return the stored data; there is no bypass hazard because accesses never overlap.

Reset
REQ-033 While rst_n=0: state=IDLE, counter=0, ready=0, err=0, busy=0, rdata=0, all request latches cleared.
REQ-034 Memory array contents SHALL NOT be reset.
REQ-035 rst_n assertion in BUSY SHALL abort the access with no write and no ready pulse.
REQ-036 After rst_n deasserts, the first rising edge with req=1 SHALL be accepted as E0.

Verification
REQ-037 WAIT=2: word store 0xDEADBEEF @0x10, then word load @0x10 -> ready exactly 2 cycles after each sample edge, rdata=0xDEADBEEF, err=0, busy high 3 cycles per access.
REQ-038 Over word 0x11223344 @0x20: sb 0xAA @0x21, lbu @0x21, lb @0x21, lw @0x20 -> rdata 0x000000AA, 0xFFFFFFAA, 0x1122AA44.
REQ-039 Over word 0x11228344 @0x40: lh @0x42, lhu @0x42, lh @0x40 -> rdata 0x00001122, 0x00001122, 0xFFFF8344.
REQ-040 Misaligned accesses: lw @0x22, sh @0x23, size=3 -> each ready with err=1 and rdata=0; a following lw @0x20 shows the word unchanged.
REQ-041 req held high for 10 cycles with WAIT=2 -> exactly 2 accesses complete, ready pulses 4 cycles apart.
REQ-042 Reset abort: sw 0x12345678 @0x30 issued, rst_n pulsed low in BUSY -> no ready pulse; a later lw @0x30 returns the prior contents.
REQ-043 Wrap-around: DEPTH_LOG2=8, sw 0xCAFEF00D @0x400 -> lw @0x000 returns 0xCAFEF00D.
